mem_arbiter_rr: RTL and testbench

- N-client round-robin memory arbiter. It is the parametrised successor to the 2-client NTT memory arbiter.
- Sits between NTT/twiddle/load-store clients and a single memory back-end port (DPI bridge or DRAM controller).
- Replaces whole-array transfers with per-beat valid/ready streaming.
- Splits long bursts into chunks of at most MAX_CHUNK beats and acknowledges each client with a one-cycle pulse.

---
 rtl/mem_arbiter_rr_if.sv | 55 +++++
 rtl/mem_arbiter_rr.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr_if
// Bundles the client-side request/data signals and the single memory back-end
// port of the round-robin memory arbiter.
//   Client side : req, rw, addr, len (flattened per client), grant, ack,
//                 wdata, wvalid, wready, rdata (shared), rvalid (per client)
//   Back-end    : mem_req, mem_rw, mem_addr, mem_len, mem_gnt,
//                 mem_wdata, mem_wvalid, mem_wready, mem_rdata, mem_rvalid
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding environment (clients plus back-end)
// -----------------------------------------------------------------------------
interface mem_arbiter_rr_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 48,
    parameter int LEN_W       = 32,
    parameter int DATA_W      = 64
);
    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS-1:0]        rw;
    logic [NUM_CLIENTS*ADDR_W-1:0] addr;
    logic [NUM_CLIENTS*LEN_W-1:0]  len;
    logic [NUM_CLIENTS-1:0]        grant;
    logic [NUM_CLIENTS-1:0]        ack;
    logic [NUM_CLIENTS*DATA_W-1:0] wdata;
    logic [NUM_CLIENTS-1:0]        wvalid;
    logic [NUM_CLIENTS-1:0]        wready;
    logic [DATA_W-1:0]             rdata;
    logic [NUM_CLIENTS-1:0]        rvalid;

    logic                          mem_req;
    logic                          mem_rw;
    logic [ADDR_W-1:0]             mem_addr;
    logic [LEN_W-1:0]              mem_len;
    logic                          mem_gnt;
    logic [DATA_W-1:0]             mem_wdata;
    logic                          mem_wvalid;
    logic                          mem_wready;
    logic [DATA_W-1:0]             mem_rdata;
    logic                          mem_rvalid;

    modport slave (
        input  req, rw, addr, len, wdata, wvalid,
        input  mem_gnt, mem_wready, mem_rdata, mem_rvalid,
        output grant, ack, wready, rdata, rvalid,
        output mem_req, mem_rw, mem_addr, mem_len, mem_wdata, mem_wvalid
    );

    modport master (
        output req, rw, addr, len, wdata, wvalid,
        output mem_gnt, mem_wready, mem_rdata, mem_rvalid,
        input  grant, ack, wready, rdata, rvalid,
        input  mem_req, mem_rw, mem_addr, mem_len, mem_wdata, mem_wvalid
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
// N-client round-robin memory arbiter. One client owns the back-end port for
// its whole burst; the burst is issued as commands of at most MAX_CHUNK beats,
// data streams per beat with valid/ready, and the owner gets a one-cycle ack.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_rr_if.slave (client request/data + back-end port)
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 48,
    parameter int LEN_W       = 32,
    parameter int DATA_W      = 64,
    parameter int MAX_CHUNK   = 256
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_rr_if.slave  bus
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_ptr, r_owner, w_pick, w_idx;
    logic [IDX_W:0]           w_sum;
    logic                     w_pick_vld;
    logic [NUM_CLIENTS-1:0]   r_grant, r_ack, r_rvalid_p1;
    logic                     r_cur_rw;
    logic [ADDR_W-1:0]        r_cur_addr;
    logic [LEN_W-1:0]         r_remaining, r_chunk, r_beat_cnt;
    logic [LEN_W-1:0]         w_chunk, w_rem_after;
    logic [DATA_W-1:0]        r_rdata_p1;
    logic                     w_wr_phase, w_beat, w_last_beat, w_arb;

    logic [ADDR_W-1:0]        w_addr  [NUM_CLIENTS];
    logic [LEN_W-1:0]         w_len   [NUM_CLIENTS];
    logic [DATA_W-1:0]        w_wdata [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign w_addr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
        assign w_len[g]   = bus.len[g*LEN_W +: LEN_W];
        assign w_wdata[g] = bus.wdata[g*DATA_W +: DATA_W];
    end

    // Round-robin search from r_ptr+1; scanning farthest-first lets the
    // nearest requester overwrite the result without a break.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_CLIENTS))
                w_sum = w_sum - (IDX_W+1)'(NUM_CLIENTS);
            w_idx = w_sum[IDX_W-1:0];
            if (bus.req[w_idx]) begin
                w_pick     = w_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    // A request seen while ack is still high belongs to the finished burst.
    assign w_arb       = w_pick_vld && (r_ack == '0);
    assign w_chunk     = (r_remaining > LEN_W'(MAX_CHUNK)) ? LEN_W'(MAX_CHUNK) : r_remaining;
    assign w_rem_after = r_remaining - r_chunk;
    assign w_wr_phase  = (r_state == S_DATA) && r_cur_rw;
    assign w_beat      = r_cur_rw ? (bus.wvalid[r_owner] & bus.mem_wready) : bus.mem_rvalid;
    assign w_last_beat = (r_state == S_DATA) && w_beat && (r_beat_cnt == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.mem_req    = 1'b0;
        bus.mem_rw     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_len    = '0;
        bus.mem_wdata  = '0;
        bus.mem_wvalid = 1'b0;
        bus.wready     = '0;
        case (r_state)
            S_IDLE: if (w_arb) w_state_nxt = S_CMD;
            S_CMD: begin
                if (r_remaining == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    bus.mem_req  = 1'b1;
                    bus.mem_rw   = r_cur_rw;
                    bus.mem_addr = r_cur_addr;
                    bus.mem_len  = w_chunk;
                    if (bus.mem_gnt) w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wr_phase) begin
                    bus.mem_wdata  = w_wdata[r_owner];
                    bus.mem_wvalid = bus.wvalid[r_owner];
                    bus.wready     = bus.mem_wready ? r_grant : '0;
                end
                if (w_last_beat)
                    w_state_nxt = (w_rem_after == '0) ? S_DONE : S_CMD;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= IDX_W'(NUM_CLIENTS - 1);
            r_owner     <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_rvalid_p1 <= '0;
            r_rdata_p1  <= '0;
            r_cur_rw    <= 1'b0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_chunk     <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_ack       <= '0;
            r_rvalid_p1 <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb) begin
                        r_grant     <= NUM_CLIENTS'(1) << w_pick;
                        r_owner     <= w_pick;
                        r_ptr       <= w_pick;
                        r_cur_rw    <= bus.rw[w_pick];
                        r_cur_addr  <= w_addr[w_pick];
                        r_remaining <= w_len[w_pick];
                    end
                end
                S_CMD: begin
                    if ((r_remaining != '0) && bus.mem_gnt) begin
                        r_chunk    <= w_chunk;
                        r_beat_cnt <= w_chunk;
                    end
                end
                S_DATA: begin
                    // Read beats reach the owner one cycle after the back-end.
                    if (!r_cur_rw && bus.mem_rvalid) begin
                        r_rvalid_p1 <= r_grant;
                        r_rdata_p1  <= bus.mem_rdata;
                    end
                    if (w_beat) r_beat_cnt <= r_beat_cnt - LEN_W'(1);
                    if (w_last_beat) begin
                        r_remaining <= w_rem_after;
                        r_cur_addr  <= r_cur_addr + ADDR_W'(r_chunk) * ADDR_W'(DATA_W / 8);
                    end
                end
                S_DONE: begin
                    r_ack   <= r_grant;
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant  = r_grant;
    assign bus.ack    = r_ack;
    assign bus.rvalid = r_rvalid_p1;
    assign bus.rdata  = r_rdata_p1;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;
    localparam int NC = 4;
    localparam int AW = 48;
    localparam int LW = 32;
    localparam int DW = 64;
    localparam int MC = 4;

    typedef struct packed {logic rw; logic [AW-1:0] addr; logic [LW-1:0] len;} job_t;
    typedef struct packed {logic [3:0] c; logic [DW-1:0] d;} rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) bus ();

    mem_arbiter_rr #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_CHUNK(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    job_t             jobq [NC][$];
    logic [DW-1:0]    wq   [NC][$];
    int               exp_grant[$];
    int               exp_ack[$];
    logic [AW+LW:0]   exp_cmd[$];
    rd_t              exp_rd[$];
    logic [DW-1:0]    exp_wr[$];
    logic [DW-1:0]    bk_rdq[$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int gnt_delay = 0;
    bit wr_toggle = 1'b0;
    bit wgap = 1'b0;
    bit stray = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s got %0h expected none", nm, act);
    endtask

    function automatic int pending();
        int s = exp_grant.size() + exp_ack.size() + exp_cmd.size() + exp_rd.size() + exp_wr.size();
        for (int c = 0; c < NC; c++) s += jobq[c].size();
        return s;
    endfunction

    task automatic drain(input string nm);
        int n = 0;
        while (pending() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_drain got %0d outstanding expected 0", nm, pending());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic job(input int c, input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l);
        job_t j;
        j.rw = rw; j.addr = a; j.len = l;
        jobq[c].push_back(j);
    endtask

    task automatic ecmd(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l);
        exp_cmd.push_back({rw, a, l});
    endtask

    task automatic erd(input int c, input logic [DW-1:0] d);
        rd_t e;
        e.c = 4'(c); e.d = d;
        exp_rd.push_back(e);
        bk_rdq.push_back(d);
    endtask

    // Client model: holds req while a job is queued, retires it on ack,
    // streams write beats and retires each on a wvalid/wready handshake.
    initial begin
        logic [NC-1:0] ack_s, hs_s;
        int cyc;
        cyc = 0;
        bus.req = '0; bus.rw = '0; bus.addr = '0; bus.len = '0;
        bus.wdata = '0; bus.wvalid = '0;
        forever begin
            @(negedge clk);
            ack_s = bus.ack;
            hs_s  = bus.wvalid & bus.wready;
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < NC; c++) begin
                if (hs_s[c] && wq[c].size() > 0) void'(wq[c].pop_front());
                if (ack_s[c] && jobq[c].size() > 0) void'(jobq[c].pop_front());
                if (jobq[c].size() > 0) begin
                    bus.req[c] = 1'b1;
                    bus.rw[c]  = jobq[c][0].rw;
                    bus.addr[c*AW +: AW] = jobq[c][0].addr;
                    bus.len[c*LW +: LW]  = jobq[c][0].len;
                end else begin
                    bus.req[c] = 1'b0;
                end
                if (wq[c].size() > 0 && !(wgap && (cyc % 3 == 1))) begin
                    bus.wvalid[c] = 1'b1;
                    bus.wdata[c*DW +: DW] = wq[c][0];
                end else begin
                    bus.wvalid[c] = 1'b0;
                end
            end
        end
    end

    // Back-end model: grants after gnt_delay cycles, returns read beats.
    initial begin
        int rd_left, wait_cnt;
        bit ph;
        rd_left = 0; wait_cnt = 0; ph = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_wready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = ~ph;
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata = '0;
            bus.mem_wready = wr_toggle ? ph : 1'b1;
            if (rst) begin
                rd_left = 0;
                wait_cnt = 0;
            end else begin
                if (rd_left > 0) begin
                    bus.mem_rvalid = 1'b1;
                    if (bk_rdq.size() > 0) bus.mem_rdata = bk_rdq.pop_front();
                    rd_left--;
                end else if (stray) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = 64'hDEAD_BEEF;
                    stray = 1'b0;
                end
                if (bus.mem_req) begin
                    if (wait_cnt >= gnt_delay) begin
                        bus.mem_gnt = 1'b1;
                        wait_cnt = 0;
                        if (!bus.mem_rw) rd_left = int'(bus.mem_len);
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [NC-1:0]  prev_grant;
        logic [AW+LW:0] prev_cmd;
        bit             prev_req;
        prev_grant = '0; prev_cmd = '0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_grant = '0;
                prev_req = 1'b0;
            end else begin
                if (bus.mem_req) begin
                    if (prev_req) chk("cmd_hold", {bus.mem_rw, bus.mem_addr, bus.mem_len}, prev_cmd);
                    if (bus.mem_gnt) begin
                        if (exp_cmd.size() == 0) unexpected("cmd", {bus.mem_rw, bus.mem_addr, bus.mem_len});
                        else chk("cmd", {bus.mem_rw, bus.mem_addr, bus.mem_len}, exp_cmd.pop_front());
                        prev_req = 1'b0;
                    end else begin
                        prev_req = 1'b1;
                        prev_cmd = {bus.mem_rw, bus.mem_addr, bus.mem_len};
                    end
                end else begin
                    prev_req = 1'b0;
                end
                if (bus.mem_wvalid && bus.mem_wready) begin
                    if (exp_wr.size() == 0) unexpected("wr_beat", bus.mem_wdata);
                    else chk("wr_beat", bus.mem_wdata, exp_wr.pop_front());
                end
                if (bus.rvalid != '0) begin
                    rd_cnt++;
                    if (exp_rd.size() == 0) begin
                        unexpected("rd_beat", {bus.rvalid, bus.rdata});
                    end else begin
                        rd_t e;
                        e = exp_rd.pop_front();
                        chk("rd_client", bus.rvalid, NC'(1) << e.c);
                        chk("rd_data", bus.rdata, e.d);
                    end
                end
                if (bus.ack != '0) begin
                    if (exp_ack.size() == 0) unexpected("ack", bus.ack);
                    else chk("ack", bus.ack, NC'(1) << exp_ack.pop_front());
                end
                if (bus.grant != prev_grant && bus.grant != '0) begin
                    if (prev_grant != '0) unexpected("grant_preempt", bus.grant);
                    else if (exp_grant.size() == 0) unexpected("grant", bus.grant);
                    else chk("grant", bus.grant, NC'(1) << exp_grant.pop_front());
                end
                prev_grant = bus.grant;
            end
        end
    end

    initial begin
        int base, n;
        bit hit;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_len", bus.mem_len, 0);
        chk("rst_rdata", bus.rdata, 0);
        #2 rst = 1'b0;

        // Round-robin fairness, client 0 queues a second job
        job(0, 1'b0, 48'h100, 1); job(0, 1'b0, 48'h500, 1);
        job(1, 1'b0, 48'h200, 1); job(2, 1'b0, 48'h300, 1); job(3, 1'b0, 48'h400, 1);
        for (int i = 0; i < 5; i++) begin
            exp_grant.push_back(i % 4);
            exp_ack.push_back(i % 4);
            ecmd(1'b0, 48'h100 * (i + 1), 1);
            erd(i % 4, 64'h11 * (i + 1));
        end
        drain("rr");

        // Stray back-end beat while idle must not reach any client
        stray = 1'b1;
        repeat (4) @(negedge clk);

        // Single read, client 2
        job(2, 1'b0, 48'h1000, 3);
        exp_grant.push_back(2); exp_ack.push_back(2);
        ecmd(1'b0, 48'h1000, 3);
        erd(2, 64'hA); erd(2, 64'hB); erd(2, 64'hC);
        drain("read");

        // Chunked write, client 1, 10 beats split 4/4/2
        job(1, 1'b1, 48'h2000, 10);
        exp_grant.push_back(1); exp_ack.push_back(1);
        ecmd(1'b1, 48'h2000, 4); ecmd(1'b1, 48'h2020, 4); ecmd(1'b1, 48'h2040, 2);
        for (int i = 0; i < 10; i++) begin
            wq[1].push_back(64'h100 + 64'(i));
            exp_wr.push_back(64'h100 + 64'(i));
        end
        drain("chunk");

        // Back-pressure: toggling mem_wready, wvalid gaps, delayed grant
        gnt_delay = 5; wr_toggle = 1'b1; wgap = 1'b1;
        job(3, 1'b1, 48'h3000, 4);
        exp_grant.push_back(3); exp_ack.push_back(3);
        ecmd(1'b1, 48'h3000, 4);
        for (int i = 0; i < 4; i++) begin
            wq[3].push_back(64'hBEEF0 + 64'(i));
            exp_wr.push_back(64'hBEEF0 + 64'(i));
        end
        drain("bp");
        gnt_delay = 0; wr_toggle = 1'b0; wgap = 1'b0;

        // Zero-length burst: ack two cycles after grant, no command
        job(0, 1'b0, 48'h0, 0);
        exp_grant.push_back(0); exp_ack.push_back(0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (bus.grant[0]) hit = 1'b1;
        end
        n = 0;
        if (hit) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                n++;
                if (bus.ack[0]) break;
            end
        end
        chk("zero_len_ack_delay", n, 2);
        drain("zero");

        // Reset during the second beat of a len=8 read
        job(2, 1'b0, 48'h4000, 8);
        exp_grant.push_back(2);
        ecmd(1'b0, 48'h4000, 4);
        for (int i = 0; i < 4; i++) erd(2, 64'h70 + 64'(i));
        base = rd_cnt;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (rd_cnt == base + 1) hit = 1'b1;
        end
        chk("mid_reset_reached", hit, 1);
        #1 rst = 1'b1;
        #1;
        chk("mrst_grant", bus.grant, 0);
        chk("mrst_rvalid", bus.rvalid, 0);
        chk("mrst_ack", bus.ack, 0);
        chk("mrst_mem_req", bus.mem_req, 0);
        chk("mrst_mem_addr", bus.mem_addr, 0);
        chk("mrst_mem_len", bus.mem_len, 0);
        chk("mrst_rdata", bus.rdata, 0);
        exp_grant.delete(); exp_ack.delete(); exp_cmd.delete();
        exp_rd.delete(); exp_wr.delete(); bk_rdq.delete();
        for (int c = 0; c < NC; c++) begin
            jobq[c].delete();
            wq[c].delete();
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        job(3, 1'b0, 48'h600, 1); job(0, 1'b0, 48'h700, 1);
        exp_grant.push_back(0); exp_grant.push_back(3);
        exp_ack.push_back(0); exp_ack.push_back(3);
        ecmd(1'b0, 48'h700, 1); ecmd(1'b0, 48'h600, 1);
        erd(0, 64'h88); erd(3, 64'h99);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
